// File: rtl/prog_loader_if.sv
// Bundled loader signals: the upstream byte stream, the reload request,
// the instruction-memory write port and the core control/status lines.
// The master modport is the environment side; the slave modport is the loader.
interface prog_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       reload;
  logic       im_we;
  logic [7:0] im_addr;
  logic [7:0] im_wdata;
  logic       cpu_reset;
  logic       done;
  logic       error;

  modport master (
    output rx_valid, rx_data, reload,
    input  rx_ready, im_we, im_addr, im_wdata, cpu_reset, done, error
  );

  modport slave (
    input  rx_valid, rx_data, reload,
    output rx_ready, im_we, im_addr, im_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a framed image (LEN, payload, optional CSUM) over a
// byte stream, writes it into instruction memory from address 0 and keeps the
// core in reset until the image is complete.
// Optional feature: define LOADER_CHECKSUM_EN to expect and verify a trailing
// checksum byte; a mismatch parks the loader in an error state.
module prog_loader (
  input logic          clock,
  input logic          reset,
  prog_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StLen, StData, StCsum, StFlush, StDone, StErr} state_e;
`else
  typedef enum logic [1:0] {StLen, StData, StFlush, StDone} state_e;
`endif

  state_e     state_q, state_d;
  // Nine bits so LEN = 0 can stand for a full 256-word image.
  logic [8:0] count_q, count_d;
  logic [7:0] addr_q, addr_d;
  logic       im_we_q, im_we_d;
  logic [7:0] im_addr_q, im_addr_d;
  logic [7:0] im_wdata_q, im_wdata_d;
  logic       cpu_reset_q, cpu_reset_d;
  logic       done_q, done_d;
  logic       rx_ready;
  logic       accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_chk;
  logic       error_q, error_d;
`endif

  // Ready only in receiving states, and never while reset is asserted.
  always_comb begin
    rx_ready = 1'b0;
    if (!reset) begin
`ifdef LOADER_CHECKSUM_EN
      rx_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
`else
      rx_ready = (state_q == StLen) || (state_q == StData);
`endif
    end
  end

  assign accept = bus.rx_valid && rx_ready;

  // Next-state, datapath updates and registered-output next values.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    sum_chk    = sum_q + bus.rx_data;
`endif

    case (state_q)
      StLen: begin
        if (accept) begin
          state_d = StData;
          count_d = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          addr_d  = 8'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      StData: begin
        if (accept) begin
          im_we_d    = 1'b1;
          im_addr_d  = addr_q;
          im_wdata_d = bus.rx_data;
          // Wraps to 0 after a 256-word image; never used again in that frame.
          addr_d     = addr_q + 8'd1;
          count_d    = count_q - 9'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_chk;
          if (count_q == 9'd1) state_d = StCsum;
`else
          if (count_q == 9'd1) state_d = StFlush;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) state_d = (sum_chk == 8'd0) ? StFlush : StErr;
      end
      StErr: begin
        if (bus.reload) state_d = StLen;
      end
`endif
      // One idle cycle so the last memory write lands before the core starts.
      StFlush: state_d = StDone;
      StDone: begin
        if (bus.reload) state_d = StLen;
      end
      default: state_d = StLen;
    endcase

    // Status rises one cycle after entering DONE/ERR, but falls with the reload edge.
    done_d      = (state_q == StDone) && (state_d == StDone);
    cpu_reset_d = !done_d;
`ifdef LOADER_CHECKSUM_EN
    error_d     = (state_q == StErr) && (state_d == StErr);
`endif
  end

  // State and registered outputs with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StLen;
      count_q     <= 9'd0;
      addr_q      <= 8'd0;
      im_we_q     <= 1'b0;
      im_addr_q   <= 8'd0;
      im_wdata_q  <= 8'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      error_q     <= error_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wdata  = im_wdata_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.done      = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif

endmodule
